mdsa_sort_ctrl: RTL and testbench

//  Sequencer for the N x N multidimensional sorting array (MDSA).
//  - Drives the array's en/start/trans/dir controls through one complete sort: load, then NUM_PASSES sorting passes.
//  - Alternates row/column direction patterns per pass, giving a shear-sort style schedule.
//  - Presents a req/busy and result_valid/result_ready handshake to the host datapath.

---
 rtl/mdsa_sort_ctrl.sv | 112 +++++++++++
 tb/tb_mdsa_sort_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdsa_sort_ctrl.sv
// Control sequencer for the N x N multidimensional sorting array.
// It loads the array and runs NUM_PASSES shear-sort passes, switching the dir pattern between rows and columns.
module mdsa_sort_ctrl #(
  parameter int             N          = 8,
  parameter int             NUM_PASSES = 7,
  parameter int             OEN_LAT    = 8,
  parameter logic [N-1:0]   ROW_DIR    = 8'b10101010,
  parameter logic [N-1:0]   COL_DIR    = 8'b00000000,
  localparam int            PW         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          busy_o,
  output logic          result_valid_o,
  input  logic          result_ready_i,
  output logic          sort_en_o,
  output logic          sort_start_o,
  output logic          sort_trans_o,
  output logic [N-1:0]  sort_dir_o,
  output logic [PW-1:0] pass_idx_o
);

  localparam int WW = (OEN_LAT > 1) ? $clog2(OEN_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [N-1:0]  dir_q, dir_d;
  logic          en_q, start_q, trans_q, busy_q, valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: if (req_i) begin
        state_d = S_LOAD;
        pass_d  = '0;
        dir_d   = ROW_DIR;
      end
      S_LOAD:  state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == WW'(OEN_LAT - 1)) begin
          state_d = (pass_q == PW'(NUM_PASSES - 1)) ? S_DONE : S_STEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_WAIT;
        cnt_d   = '0;
        pass_d  = pass_q + 1'b1;
        // The new pass is even exactly when the current one is odd.
        dir_d   = pass_q[0] ? ROW_DIR : COL_DIR;
      end
      S_DONE: if (result_ready_i) begin
        state_d = S_IDLE;
        pass_d  = '0;
        dir_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The control outputs are decoded from the next state and then registered.
  // This way they change on the same edge as the state, and trans cannot glitch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      dir_q   <= '0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
      trans_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      en_q    <= (state_d != S_IDLE);
      start_q <= (state_d == S_LOAD) || (state_d == S_LATCH);
      trans_q <= (state_d == S_LATCH) || (state_d == S_STEP);
      busy_q  <= (state_d != S_IDLE);
      valid_q <= (state_d == S_DONE);
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign sort_en_o      = en_q;
  assign sort_start_o   = start_q;
  assign sort_trans_o   = trans_q;
  assign sort_dir_o     = dir_q;
  assign pass_idx_o     = pass_q;

endmodule

// File: tb/tb_mdsa_sort_ctrl.sv
// Scoreboard bench for mdsa_sort_ctrl: each req pushes the trans pulses and result events we expect to see.
// Monitors pop and compare them. A second instance uses the minimal configuration.
module tb_mdsa_sort_ctrl;

  typedef struct {
    int         cyc;
    bit         kind;   // 0: trans pulse, 1: result_valid rise
    bit         start;
    logic [7:0] dir;
    int         pass;
  } ev_t;

  bit clk;
  logic rst, req, ready, req2, ready2;
  logic busy, valid, en, start, trans;
  logic [7:0] dir;
  logic [2:0] pidx;
  logic busy2, valid2, en2, start2, trans2;
  logic [7:0] dir2;
  logic [0:0] pidx2;

  ev_t sb[$];
  ev_t sb2[$];
  int  n_chk = 0, n_fail = 0;
  int  cyc = 0;
  bit  v_prev = 0, v2_prev = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdsa_sort_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .busy_o(busy), .result_valid_o(valid),
    .result_ready_i(ready), .sort_en_o(en), .sort_start_o(start), .sort_trans_o(trans),
    .sort_dir_o(dir), .pass_idx_o(pidx)
  );

  mdsa_sort_ctrl #(.NUM_PASSES(1), .OEN_LAT(1)) u_small (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .busy_o(busy2), .result_valid_o(valid2),
    .result_ready_i(ready2), .sort_en_o(en2), .sort_start_o(start2), .sort_trans_o(trans2),
    .sort_dir_o(dir2), .pass_idx_o(pidx2)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Default job with req sampled at edge e0: the LATCH pulse comes at e0+1 and the STEP pulses every 9 cycles from e0+10.
  // result_valid rises at e0+64.
  task automatic push_job(input int e0);
    sb.push_back('{e0 + 1, 1'b0, 1'b1, 8'hAA, 0});
    for (int k = 0; k < 6; k++)
      sb.push_back('{e0 + 10 + 9 * k, 1'b0, 1'b0, (k % 2) ? 8'h00 : 8'hAA, k});
    sb.push_back('{e0 + 64, 1'b1, 1'b0, 8'hAA, 6});
  endtask

  task automatic wait_valid(input bit sel);
    int i;
    i = 0;
    while (!(sel ? valid2 : valid) && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (!(sel ? valid2 : valid)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_valid%0d: result_valid never rose", sel);
    end
  endtask

  always @(negedge clk) begin
    if (trans || (valid && !v_prev)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: trans=%0b valid=%0b expected none (cycle %0d)", trans, valid, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_kind", {31'd0, valid && !v_prev}, {31'd0, e.kind});
        chk("ev_start", {31'd0, start}, {31'd0, e.start});
        chk("ev_dir", {24'd0, dir}, {24'd0, e.dir});
        chk("ev_pass", {29'd0, pidx}, e.pass);
      end
    end
    v_prev <= valid;
  end

  always @(negedge clk) begin
    if (trans2 || (valid2 && !v2_prev)) begin
      if (sb2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event_small: trans=%0b valid=%0b expected none (cycle %0d)", trans2, valid2, cyc);
      end else begin
        ev_t e;
        e = sb2.pop_front();
        chk("small_ev_cycle", cyc, e.cyc);
        chk("small_ev_kind", {31'd0, valid2 && !v2_prev}, {31'd0, e.kind});
        chk("small_ev_start", {31'd0, start2}, {31'd0, e.start});
        chk("small_ev_dir", {24'd0, dir2}, {24'd0, e.dir});
        chk("small_ev_pass", {31'd0, pidx2}, e.pass);
      end
    end
    v2_prev <= valid2;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1; req = 1; ready = 0; req2 = 0; ready2 = 0;
    // Reset with req high
    repeat (2) begin
      @(negedge clk);
      chk("rst_outs", {20'd0, en, start, trans, busy, valid, dir, pidx}, 0);
      chk("rst_outs_small", {22'd0, en2, start2, trans2, busy2, valid2, dir2, pidx2}, 0);
    end
    rst = 0; req = 0;
    @(negedge clk);
    chk("idle_after_rst", {31'd0, busy}, 0);

    // Single job, plus a req pulse while busy that must be ignored
    e0 = cyc + 1;
    push_job(e0);
    req = 1;
    @(negedge clk);
    req = 0;
    chk("load_ctl", {28'd0, en, start, trans, busy}, 32'b1101);
    chk("load_dir", {24'd0, dir}, 32'hAA);
    repeat (15) @(negedge clk);
    req = 1;
    repeat (2) @(negedge clk);
    req = 0;
    wait_valid(0);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("idle_after_done", {30'd0, busy, valid}, 0);
    @(negedge clk);
    chk("no_queued_req", {31'd0, busy}, 0);

    // Hold in DONE, then a back-to-back job with req held high
    e0 = cyc + 1;
    push_job(e0);
    req = 1;
    @(negedge clk);
    req = 0;
    wait_valid(0);
    repeat (20) begin
      chk("hold", {22'd0, valid, en, dir}, {22'd0, 1'b1, 1'b1, 8'hAA});
      @(negedge clk);
    end
    ready = 1; req = 1;
    e0 = cyc + 2;
    push_job(e0);
    @(negedge clk);
    ready = 0;
    chk("b2b_idle", {31'd0, busy}, 0);
    @(negedge clk);
    req = 0;
    chk("b2b_load", {28'd0, en, start, trans, busy}, 32'b1101);

    // Abort in the pass-3 WAIT (edges e0+29..e0+36)
    while (cyc < e0 + 31) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_outs", {20'd0, en, start, trans, busy, valid, dir, pidx}, 0);
    sb.delete();
    repeat (10) @(negedge clk);
    chk("abort_stays_idle", {30'd0, busy, valid}, 0);
    e0 = cyc + 1;
    push_job(e0);
    req = 1;
    @(negedge clk);
    req = 0;
    wait_valid(0);
    ready = 1;
    @(negedge clk);
    ready = 0;

    // Minimal config: NUM_PASSES=1, OEN_LAT=1, with req held while busy
    e0 = cyc + 1;
    sb2.push_back('{e0 + 1, 1'b0, 1'b1, 8'hAA, 0});
    sb2.push_back('{e0 + 3, 1'b1, 1'b0, 8'hAA, 0});
    req2 = 1;
    repeat (3) @(negedge clk);
    req2 = 0;
    wait_valid(1);
    chk("small_pass", {31'd0, pidx2}, 0);
    ready2 = 1;
    @(negedge clk);
    ready2 = 0;
    chk("small_idle", {31'd0, busy2}, 0);
    @(negedge clk);
    chk("small_no_restart", {31'd0, busy2}, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("sb2_drained", sb2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
